// File: rtl/tx_byte_fifo.sv
// Show-ahead byte FIFO feeding the tx serialiser in the bit-clock domain.
// A start threshold or flush opens a burst; the burst closes when the FIFO drains.
module tx_byte_fifo #(
  parameter int ADDR_W      = 4,
  parameter int START_LEVEL = 4
) (
  input  logic              clk_bit,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              flush,
  input  logic              read_enable,
  output logic [7:0]        d_out,
  output logic              d_out_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underrun,
  input  logic              clear_status
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] START_CNT = (ADDR_W + 1)'(START_LEVEL);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  typedef enum logic {
    S_WAIT,
    S_STREAM
  } state_t;

  logic [7:0]        mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;

  logic              pop;
  logic              push;
  logic              push_rejected;
  logic              valid;

  // Output is gated so d_out reads 8'h00 whenever nothing is on offer.
  always_comb begin
    valid         = (state_q == S_STREAM) && (count_q != '0);
    pop           = read_enable && valid;
    push          = wr_en && (!full_q || pop);
    push_rejected = wr_en && full_q && !pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end
    if (push && !pop) begin
      count_d = count_q + ONE_CNT;
    end else if (pop && !push) begin
      count_d = count_q - ONE_CNT;
    end
    full_d = (count_d == DEPTH_CNT);
  end

  // Transitions look at the post-edge occupancy so the burst opens one cycle after the threshold push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if ((count_d >= START_CNT) || (flush && (count_d != '0))) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (count_d == '0) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Sticky flags: a set event in the same cycle as clear_status wins.
  always_comb begin
    overflow_d = clear_status ? 1'b0 : overflow_q;
    underrun_d = clear_status ? 1'b0 : underrun_q;
    if (push_rejected) begin
      overflow_d = 1'b1;
    end
    if ((state_q == S_STREAM) && (count_q == '0) && read_enable) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_bit or negedge rst) begin
    if (!rst) begin
      state_q    <= S_WAIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_bit) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    d_out       = valid ? mem[rd_ptr_q] : 8'h00;
    d_out_valid = valid;
    full        = full_q;
    count       = count_q;
    overflow    = overflow_q;
    underrun    = underrun_q;
  end

endmodule

// File: doc/tx_byte_fifo.md
Name: tx_byte_fifo

Overview:
- Byte buffer directly upstream of the tx serialiser, in the bit-clock domain.
- The user side pushes bytes at arbitrary times. The tx side pops one byte per 10-bit symbol slot through its read_enable strobe.
- A start threshold gathers bytes into bursts, so tx does not fall back to comma idle between closely spaced writes.
- Provides occupancy, full, and sticky overflow/underrun status.

Parameters:
- ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W = 16 bytes.
- START_LEVEL, 4, occupancy at which a burst starts; legal range 1..2**ADDR_W.

Ports:
- clk_bit  in  1  bit clock shared with tx.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- wr_data  in  8  byte to push.
- wr_en  in  1  push strobe, one byte per cycle while high.
- flush  in  1  single-cycle pulse: start a burst with whatever is buffered.
- read_enable  in  1  pop strobe from tx; pops only when d_out_valid=1.
- d_out  out  8  head-of-FIFO byte (show-ahead), drives tx d_in.
- d_out_valid  out  1  drives tx d_in_valid.
- full  out  1  occupancy == depth.
- count  out  ADDR_W+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a write was attempted while full.
- underrun  out  1  sticky: read_enable arrived in STREAM state with the FIFO empty.
- clear_status  in  1  clears overflow and underrun.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; state goes to WAIT.
  - Outputs: d_out_valid=0, full=0, overflow=0, underrun=0, d_out=8'h00.
  - Memory contents are not reset.
- Release: reset deassertion is used directly; the first push is accepted on the first rising clk_bit edge with rst=1.
- Storage: 2**ADDR_W x 8 array.
  - Write and read pointers are ADDR_W bits and wrap modulo depth.
  - count is tracked separately, ADDR_W+1 bits.
- Push:
  - Accepted when wr_en=1 and (full=0, or a pop occurs in the same cycle).
  - A rejected push sets overflow on the next edge; the data is dropped and the pointer is unchanged.
- Pop:
  - Occurs when read_enable=1 and d_out_valid=1.
  - The read pointer advances, and d_out shows the next entry on the following cycle.
  - d_out is combinationally driven from mem[rd_ptr], so it is valid in the same cycle d_out_valid is high.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - This is legal at full; the pop frees the slot.
  - This is also legal at count=1; the new byte becomes head the next cycle.
  - At count=0, push and pop cannot coincide because d_out_valid=0.
- State machine:
  - WAIT:
    - d_out_valid=0.
    - Go to STREAM when count >= START_LEVEL.
    - Also go to STREAM when flush=1 and count>0; a flush with count=0 is ignored.
    - The transition evaluates count as updated at that edge, so d_out_valid rises one cycle after the push that reaches START_LEVEL.
  - STREAM:
    - d_out_valid = (count != 0).
    - Return to WAIT on the edge where count becomes 0, i.e. a pop of the last byte with no simultaneous push.
    - Pushes during STREAM extend the burst.
- Underrun:
  - Set when state=STREAM, count=0 and read_enable=1.
  - Cannot occur under normal flow, because of the STREAM-to-WAIT rule; it is a diagnostic only.
- Status:
  - clear_status=1 clears overflow and underrun on the next edge.
  - If a set event occurs in the same cycle, set wins.
- full = (count == 2**ADDR_W), registered alongside count.
- Reset mid-burst: everything is discarded and the FSM returns to WAIT; tx sees d_out_valid drop asynchronously and goes idle.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release -> count=0, d_out_valid=0, full=0, overflow=0, underrun=0.
- Threshold: push 8'h10,8'h11,8'h12 with START_LEVEL=4 -> d_out_valid stays 0. Push 8'h13 -> next cycle d_out_valid=1, d_out=8'h10. Pulse read_enable every 10 cycles -> bytes 10,11,12,13 appear in order. d_out_valid falls after the 4th pop and state returns to WAIT.
- Flush: push 8'hA5 only, pulse flush -> next cycle d_out_valid=1, d_out=8'hA5. One pop -> count=0, d_out_valid=0. A flush with an empty FIFO -> no change.
- Full/overflow: push 16 bytes 0x00..0x0F with no pops -> full=1, count=16. A 17th push of 8'hFF -> overflow=1, count=16, and the later pop sequence is 0x00..0x0F. Apply clear_status -> overflow=0.
- Simultaneous: at count=16, wr_en and read_enable in the same cycle -> count stays 16, overflow stays 0, and the new byte emerges 16th. At count=1 in STREAM, push plus pop -> count stays 1, d_out_valid stays 1.
- Link loopback: instantiate with tx and rx, feed bytes 0..255 continuously -> rx d_out reproduces 0..255 in order, with no idle commas inside the burst and overflow=0, underrun=0.
